// File: rtl/gates_pkg.sv
// Shared constants for the gate-input switch debouncer: channel count,
// default qualification time and the channel-to-gate-input bit mapping.
package gates_pkg;

   localparam int unsigned N_CH              = 5;
   localparam int unsigned DEF_STABLE_CYCLES = 1_000_000;

   // Bit position of each gate input inside the sw_in / sw_db vectors.
   typedef enum int unsigned {
      GATE_A = 0,
      GATE_B = 1,
      GATE_D = 2,
      GATE_E = 3,
      GATE_G = 4
   } gate_ch_e;

endpackage : gates_pkg

// File: rtl/switch_debouncer_if.sv
// Switch-side bundle: raw levels in, debounced levels and edge pulses out.
interface switch_debouncer_if #(
   parameter int unsigned N_CH = gates_pkg::N_CH
);

   logic [N_CH-1:0] sw_in;
   logic [N_CH-1:0] sw_db;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;
   logic            any_change;

   modport master (output sw_in, input sw_db, rise, fall, any_change);
   modport slave  (input sw_in, output sw_db, rise, fall, any_change);

endinterface : switch_debouncer_if

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter and
// registered rise/fall pulses for a single switch input.
module debounce_ch
   import gates_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter logic        RST_VAL       = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_in,
   output logic sw_db,
   output logic rise,
   output logic fall,
   output logic accept
);

   localparam int unsigned          CNT_W   = $clog2(STABLE_CYCLES) + 1;
   localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic             s1_q, s2_q;
   logic             db_q, db_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: every signal gets a default before the if-chain so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      cnt_d  = '0;
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (s2_q != db_q) begin
         if (cnt_q == CNT_MAX) begin
            db_d   = s2_q;
            rise_d = s2_q;
            fall_d = ~s2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // NOTE: non-blocking assignments let s2_q sample the old s1_q, which is
   // what makes the two flops a real synchronizer chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= RST_VAL;
         s2_q   <= RST_VAL;
         db_q   <= RST_VAL;
         cnt_q  <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= sw_in;
         s2_q   <= s1_q;
         db_q   <= db_d;
         cnt_q  <= cnt_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign sw_db  = db_q;
   assign rise   = rise_q;
   assign fall   = fall_q;
   // Next-cycle pulse, so the top can register any_change alongside rise/fall.
   assign accept = rise_d | fall_d;

endmodule : debounce_ch

// File: rtl/switch_debouncer.sv
// Debouncer for the gate-input switches: N_CH independent channels plus a
// single registered any_change flag.
module switch_debouncer #(
   parameter int unsigned       N_CH          = gates_pkg::N_CH,
   parameter int unsigned       STABLE_CYCLES = gates_pkg::DEF_STABLE_CYCLES,
   parameter logic [N_CH-1:0]   RST_VAL       = {N_CH{1'b0}}
) (
   input  logic               clk,
   input  logic               rst_n,
   switch_debouncer_if.slave  bus
);

   logic [N_CH-1:0] db;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;
   logic [N_CH-1:0] accept;
   logic            any_change_q, any_change_d;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_ch #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .RST_VAL       (RST_VAL[i])
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .sw_in  (bus.sw_in[i]),
         .sw_db  (db[i]),
         .rise   (rise[i]),
         .fall   (fall[i]),
         .accept (accept[i])
      );
   end

   // Same-edge acceptances on several channels collapse into one pulse.
   always_comb begin
      any_change_d = |accept;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_change_q <= 1'b0;
      end else begin
         any_change_q <= any_change_d;
      end
   end

   assign bus.sw_db      = db;
   assign bus.rise       = rise;
   assign bus.fall       = fall;
   assign bus.any_change = any_change_q;

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed scenarios followed by
// random switch activity, all compared against a sample-history model.
module tb_switch_debouncer;

   localparam int unsigned    NC = gates_pkg::N_CH;
   localparam int unsigned    SC = 4;
   localparam logic [NC-1:0]  RV = '0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   switch_debouncer_if #(.N_CH(NC)) bus ();

   switch_debouncer #(
      .N_CH          (NC),
      .STABLE_CYCLES (SC),
      .RST_VAL       (RV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: s2 is the input sampled two edges earlier; a channel
   // accepts when the last SC pre-edge s2 values all differ from its level.
   logic [NC-1:0] samp[$];
   logic [NC-1:0] hist[$];
   logic [NC-1:0] m_db, m_rise, m_fall;
   logic          m_any;

   int n_any;
   int rise_cnt[NC];
   int fall_cnt[NC];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      samp.delete();
      hist.delete();
      m_db   = RV;
      m_rise = '0;
      m_fall = '0;
      m_any  = 1'b0;
   endtask

   task automatic model_edge();
      logic [NC-1:0] s2_pre;
      logic [NC-1:0] h;
      bit            ok;
      s2_pre = (samp.size() >= 2) ? samp[samp.size()-2] : RV;
      hist.push_back(s2_pre);
      if (hist.size() > SC) void'(hist.pop_front());
      m_rise = '0;
      m_fall = '0;
      if (hist.size() == SC) begin
         for (int c = 0; c < NC; c++) begin
            ok = 1'b1;
            for (int j = 0; j < SC; j++) begin
               h = hist[j];
               if (h[c] == m_db[c]) ok = 1'b0;
            end
            if (ok) begin
               if (m_db[c]) m_fall[c] = 1'b1;
               else         m_rise[c] = 1'b1;
               m_db[c] = ~m_db[c];
            end
         end
      end
      m_any = |(m_rise | m_fall);
      samp.push_back(bus.sw_in);
      if (samp.size() > 2) void'(samp.pop_front());
   endtask

   task automatic clear_counts();
      n_any = 0;
      for (int c = 0; c < NC; c++) begin
         rise_cnt[c] = 0;
         fall_cnt[c] = 0;
      end
   endtask

   task automatic tick();
      logic [NC-1:0] r, f;
      @(posedge clk);
      model_edge();
      #1;
      check("sw_db",      32'(bus.sw_db),      32'(m_db));
      check("rise",       32'(bus.rise),       32'(m_rise));
      check("fall",       32'(bus.fall),       32'(m_fall));
      check("any_change", 32'(bus.any_change), 32'(m_any));
      r = bus.rise;
      f = bus.fall;
      if (bus.any_change === 1'b1) n_any++;
      for (int c = 0; c < NC; c++) begin
         if (r[c] === 1'b1) rise_cnt[c]++;
         if (f[c] === 1'b1) fall_cnt[c]++;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Asserts reset between edges, checks the outputs clear without a clock
   // edge, then releases on a falling edge.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      check({tag, "_sw_db"}, 32'(bus.sw_db), 32'(RV));
      check({tag, "_pulses"}, 32'({bus.rise, bus.fall, bus.any_change}), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [NC-1:0] v;
      bus.sw_in = '0;
      model_reset();
      clear_counts();
      #12;
      do_reset("por");

      // Idle after reset with inputs at the reset level.
      ticks(20);
      check("idle_db", 32'(bus.sw_db), 32'd0);
      check("idle_any", 32'(n_any), 32'd0);

      // Single channel rising: accepted on the sixth edge after the change.
      clear_counts();
      bus.sw_in = 5'b00001;
      ticks(5);
      check("lat_db0_early", 32'(bus.sw_db[0]), 32'd0);
      tick();
      check("lat_db0", 32'(bus.sw_db[0]), 32'd1);
      check("lat_rise0", 32'(bus.rise[0]), 32'd1);
      check("lat_any", 32'(bus.any_change), 32'd1);
      tick();
      check("lat_rise0_off", 32'(bus.rise[0]), 32'd0);
      check("lat_any_cnt", 32'(n_any), 32'd1);

      // Channel 1 bouncing with period 4 (never stable for 4 edges), then settling high.
      clear_counts();
      for (int i = 0; i < 12; i++) begin
         v = bus.sw_in;
         v[1] = ((i / 2) % 2 == 0);
         bus.sw_in = v;
         tick();
      end
      check("bounce_db1", 32'(bus.sw_db[1]), 32'd0);
      v = bus.sw_in;
      v[1] = 1'b1;
      bus.sw_in = v;
      ticks(5);
      check("bounce_db1_wait", 32'(bus.sw_db[1]), 32'd0);
      tick();
      check("bounce_db1_set", 32'(bus.sw_db[1]), 32'd1);
      ticks(4);
      check("bounce_rise1_cnt", 32'(rise_cnt[1]), 32'd1);

      // Return to all-low, then a simultaneous three-channel change.
      bus.sw_in = '0;
      ticks(8);
      clear_counts();
      bus.sw_in = 5'b10101;
      ticks(5);
      check("multi_db_early", 32'(bus.sw_db), 32'd0);
      tick();
      check("multi_db", 32'(bus.sw_db), 32'b10101);
      check("multi_rise", 32'(bus.rise), 32'b10101);
      ticks(3);
      check("multi_any_cnt", 32'(n_any), 32'd1);
      clear_counts();
      bus.sw_in = '0;
      ticks(5);
      tick();
      check("multi_db_low", 32'(bus.sw_db), 32'd0);
      check("multi_fall", 32'(bus.fall), 32'b10101);
      ticks(3);
      check("multi_fall_any_cnt", 32'(n_any), 32'd1);

      // Glitch of 3 cycles on channel 2 must be filtered.
      clear_counts();
      bus.sw_in = 5'b00100;
      ticks(3);
      bus.sw_in = '0;
      ticks(10);
      check("glitch_db2", 32'(bus.sw_db[2]), 32'd0);
      check("glitch_any_cnt", 32'(n_any), 32'd0);

      // Reset mid-count on channel 3 while channel 0 is already high.
      bus.sw_in = 5'b00001;
      ticks(8);
      check("pre_rst_db0", 32'(bus.sw_db[0]), 32'd1);
      bus.sw_in = 5'b01001;
      ticks(4);
      do_reset("midcnt");
      clear_counts();
      ticks(5);
      check("post_rst_db_wait", 32'(bus.sw_db), 32'd0);
      tick();
      check("post_rst_db", 32'(bus.sw_db), 32'b01001);
      check("post_rst_rise", 32'(bus.rise), 32'b01001);

      // Random activity with mean hold near the qualification time.
      bus.sw_in = '0;
      for (int i = 0; i < 400; i++) begin
         v = bus.sw_in;
         for (int c = 0; c < NC; c++) begin
            if ($urandom_range(0, 5) == 0) v[c] = ~v[c];
         end
         bus.sw_in = v;
         if (i == 200) do_reset("rand");
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_switch_debouncer

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The parameter list SHALL be: N_CH, 5, number of input channels (mapped to gate inputs a, b, d, e, g as bits 0..4).
REQ-002 The parameter list SHALL include: STABLE_CYCLES, 1000000, consecutive clock cycles a synchronized level must persist before it is accepted (legal range 1..2^24).
REQ-003 The parameter list SHALL include: RST_VAL, {N_CH{1'b0}}, debounced level loaded on reset.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 sw_in  input  N_CH  raw, asynchronous, bouncing switch levels.
REQ-008 sw_db  output  N_CH  debounced levels, registered; these drive the downstream gate inputs.
REQ-009 rise  output  N_CH  one-cycle pulse per channel on an accepted 0->1 transition of sw_db.
REQ-010 fall  output  N_CH  one-cycle pulse per channel on an accepted 1->0 transition of sw_db.
REQ-011 any_change  output  1  OR of rise and fall, registered with them.

Function
REQ-012 Each channel SHALL pass sw_in through a 2-flop synchronizer (s1, s2) before any other logic.
REQ-013 Each channel SHALL hold a counter cnt of width clog2(STABLE_CYCLES)+1 bits.
REQ-014 If s2 equals sw_db for a channel, then cnt SHALL load 0 on that edge.
REQ-015 If s2 differs from sw_db and cnt < STABLE_CYCLES-1, then cnt SHALL increment by 1.
REQ-016 If s2 differs from sw_db and cnt == STABLE_CYCLES-1, then, on that edge, sw_db SHALL load s2, cnt SHALL load 0, and the matching rise/fall bit SHALL assert.
REQ-017 Latency: with a new level held steady and first captured by s1 at edge k, sw_db SHALL change at edge k+1+STABLE_CYCLES.
REQ-018 Any return of s2 to the sw_db level before acceptance SHALL clear cnt, so that a glitch shorter than STABLE_CYCLES cycles never reaches sw_db.
REQ-019 The rise, fall and any_change outputs SHALL be high for exactly one cycle per accepted transition and SHALL be low otherwise.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be accepted on their own schedule, and same-edge acceptance SHALL produce a single any_change cycle.
REQ-021 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-022 With STABLE_CYCLES = 1, acceptance SHALL occur on the first edge at which s2 differs from sw_db.

Reset
REQ-023 When rst_n is low, s1, s2 and sw_db SHALL be forced to RST_VAL, cnt to 0, and rise, fall and any_change to 0, immediately and independent of clk.
REQ-024 Reset asserted mid-count SHALL discard the partial count, and no pulse SHALL be emitted on or after release unless a fresh full STABLE_CYCLES qualification completes.
REQ-025 Following reset release, with sw_in equal to RST_VAL, the outputs SHALL remain static.

Structure
REQ-026 N_CH, the default STABLE_CYCLES and the channel-to-gate-input bit mapping SHALL live in the shared package gates_pkg.
REQ-027 The per-channel synchronizer, counter and edge logic SHALL be a sub-module debounce_ch, instantiated N_CH times by switch_debouncer.
REQ-028 The any_change output SHALL be the only cross-channel logic.

Verification (bench uses STABLE_CYCLES = 4, RST_VAL = 0)
REQ-029 Reset with sw_in=5'b00000, release, run 20 cycles -> sw_db=0 and rise=fall=any_change=0 throughout.
REQ-030 sw_in[0] 0->1 before edge k and held -> sw_db[0]=1 from edge k+5, with rise[0] and any_change high for exactly that one cycle.
REQ-031 sw_in[1] toggling every 2 cycles for 12 cycles, then held at 1 -> sw_db[1] stays 0 until 5 edges after the final settle, followed by exactly one rise[1] pulse.
REQ-032 sw_in 0 -> 5'b10101 on one edge -> sw_db=5'b10101 on a single edge, rise=5'b10101 for one cycle, and a single any_change pulse; then sw_in -> 0 gives the fall pattern similarly.
REQ-033 sw_in[2] high for 3 cycles, then low -> sw_db[2] never changes and no pulses occur.
REQ-034 sw_in[3] held 1, rst_n pulsed low at cnt=2 -> sw_db=0 immediately; after release, rise[3] occurs 5 edges after the first post-reset s1 capture.
